// File: rtl/rggen_apb_master_bridge_if.sv
// Command, response and APB signal bundle for rggen_apb_master_bridge.
// The master modport is the bridge side. The slave modport is the host/completer environment.
interface rggen_apb_master_bridge_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  // valid/ready: a beat transfers on a clock edge where valid & ready are both 1.
  // A raised valid and its payload hold until that edge.
  logic                      i_cmd_valid;
  logic                      o_cmd_ready;
  logic                      i_cmd_write;
  logic [ADDRESS_WIDTH-1:0]  i_cmd_address;
  logic [DATA_WIDTH-1:0]     i_cmd_write_data;
  logic [DATA_WIDTH/8-1:0]   i_cmd_strobe;
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [DATA_WIDTH-1:0]     o_rsp_read_data;
  logic [1:0]                o_rsp_status;
  logic                      o_psel;
  logic                      o_penable;
  logic                      o_pwrite;
  logic [ADDRESS_WIDTH-1:0]  o_paddr;
  logic [DATA_WIDTH-1:0]     o_pwdata;
  logic [DATA_WIDTH/8-1:0]   o_pstrb;
  logic                      i_pready;
  logic [DATA_WIDTH-1:0]     i_prdata;
  logic                      i_pslverr;
  logic [1:0]                dbg_state;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_address, i_cmd_write_data, i_cmd_strobe,
    input  i_rsp_ready, i_pready, i_prdata, i_pslverr,
    output o_cmd_ready, o_rsp_valid, o_rsp_read_data, o_rsp_status,
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, dbg_state
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_address, i_cmd_write_data, i_cmd_strobe,
    output i_rsp_ready, i_pready, i_prdata, i_pslverr,
    input  o_cmd_ready, o_rsp_valid, o_rsp_read_data, o_rsp_status,
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, dbg_state
  );
endinterface

// File: rtl/rggen_apb_master_bridge.sv
// APB4 requester: one command at a time becomes an APB SETUP/ACCESS transfer.
// The bridge returns read data and status on a response port and aborts a hung completer.
module rggen_apb_master_bridge #(
  parameter int          ADDRESS_WIDTH  = 16,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                      clk,
  input logic                      rst_n,
  rggen_apb_master_bridge_if.master bus
);
  localparam int          CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST_WAIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    ACCESS   = 2'd2,
    RESPONSE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_count;

  assign bus.dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      wait_count          <= '0;
      bus.o_cmd_ready     <= 1'b0;
      bus.o_rsp_valid     <= 1'b0;
      bus.o_rsp_read_data <= '0;
      bus.o_rsp_status    <= 2'b00;
      bus.o_psel          <= 1'b0;
      bus.o_penable       <= 1'b0;
      bus.o_pwrite        <= 1'b0;
      bus.o_paddr         <= '0;
      bus.o_pwdata        <= '0;
      bus.o_pstrb         <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.o_cmd_ready <= 1'b1;
          if (bus.i_cmd_valid && bus.o_cmd_ready) begin
            bus.o_cmd_ready <= 1'b0;
            bus.o_pwrite    <= bus.i_cmd_write;
            bus.o_paddr     <= bus.i_cmd_address;
            // Reads leave pwdata untouched and drive an all-zero strobe.
            if (bus.i_cmd_write) begin
              bus.o_pwdata <= bus.i_cmd_write_data;
              bus.o_pstrb  <= bus.i_cmd_strobe;
            end else begin
              bus.o_pstrb  <= '0;
            end
            bus.o_psel <= 1'b1;
            wait_count <= '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.o_penable <= 1'b1;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (bus.i_pready) begin
            bus.o_psel          <= 1'b0;
            bus.o_penable       <= 1'b0;
            bus.o_rsp_read_data <= (!bus.o_pwrite && !bus.i_pslverr) ? bus.i_prdata : '0;
            bus.o_rsp_status    <= bus.i_pslverr ? 2'b10 : 2'b00;
            bus.o_rsp_valid     <= 1'b1;
            state               <= RESPONSE;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_count == CW'(LAST_WAIT))) begin
            // This is the last permitted stalled ACCESS cycle, so abandon the transfer.
            bus.o_psel          <= 1'b0;
            bus.o_penable       <= 1'b0;
            bus.o_rsp_read_data <= '0;
            bus.o_rsp_status    <= 2'b11;
            bus.o_rsp_valid     <= 1'b1;
            state               <= RESPONSE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        RESPONSE: begin
          if (bus.i_rsp_ready) begin
            bus.o_rsp_valid <= 1'b0;
            bus.o_cmd_ready <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// Self-checking bench for rggen_apb_master_bridge (TIMEOUT_CYCLES = 4): vector table,
// randomised transfers, and hand-written timeout, back-pressure and reset sequences.
module tb_rggen_apb_master_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rggen_apb_master_bridge_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();

  rggen_apb_master_bridge #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        hang;
    logic [31:0] prdata;
    logic        slverr;
    int          rsp_delay;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[7];
  logic [33:0] exp_q[$];
  logic [31:0] last_wdata = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic write, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    bus.i_cmd_valid      = 1'b1;
    bus.i_cmd_write      = write;
    bus.i_cmd_address    = addr;
    bus.i_cmd_write_data = wdata;
    bus.i_cmd_strobe     = strb;
  endtask

  task automatic do_xfer(input vec_t v);
    int          n;
    int          access;
    logic [33:0] exp;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    n = 0;
    while (!bus.o_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", bus.o_cmd_ready, 1);
    drive_cmd(v.write, v.addr, v.wdata, v.strb);
    exp_q.push_back({v.exp_status, v.exp_data});
    exp_wdata = v.write ? v.wdata : last_wdata;
    exp_strb  = v.write ? v.strb : 4'h0;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    check("setup_phase", {bus.o_psel, bus.o_penable, bus.o_cmd_ready}, 3'b100);
    @(negedge clk);
    access = 0;
    while (bus.o_psel && bus.o_penable && access < 50) begin
      access++;
      check("apb_stable", {bus.o_pwrite, bus.o_paddr, bus.o_pwdata, bus.o_pstrb},
            {v.write, v.addr, exp_wdata, exp_strb});
      if (!v.hang && access > v.waits) begin
        bus.i_pready  = 1'b1;
        bus.i_prdata  = v.prdata;
        bus.i_pslverr = v.slverr;
      end else begin
        bus.i_pready  = 1'b0;
        bus.i_prdata  = $urandom;
        bus.i_pslverr = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      bus.i_pready  = 1'b0;
      bus.i_pslverr = 1'b0;
    end
    check("access_cycles", access, v.hang ? 4 : v.waits + 1);
    check("rsp_valid_up", {bus.o_rsp_valid, bus.o_psel, bus.o_penable, bus.o_cmd_ready}, 4'b1000);
    if (v.write) last_wdata = v.wdata;
    if (v.hang) begin
      bus.i_pready = 1'b1;
      bus.i_prdata = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < v.rsp_delay; i++) begin
      drive_cmd(1'b1, 16'h0100, 32'h0BAD_0BAD, 4'hF);
      @(negedge clk);
      bus.i_pready = 1'b0;
      check("rsp_hold", {bus.o_rsp_valid, bus.o_cmd_ready, bus.o_psel, bus.o_rsp_status,
            bus.o_rsp_read_data}, {3'b100, v.exp_status, v.exp_data});
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b1;
    if (bus.o_rsp_valid && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("rsp_data", bus.o_rsp_read_data, exp[31:0]);
      check("rsp_status", bus.o_rsp_status, exp[33:32]);
    end
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    check("rsp_done", {bus.o_rsp_valid, bus.o_cmd_ready}, 2'b01);
  endtask

  initial begin
    vec_t v;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_write = 1'b0; bus.i_cmd_address = '0;
    bus.i_cmd_write_data = '0; bus.i_cmd_strobe = '0; bus.i_rsp_ready = 1'b0;
    bus.i_pready = 1'b0; bus.i_prdata = '0; bus.i_pslverr = 1'b0;

    // write, addr, wdata, strb, waits, hang, prdata, slverr, rsp_delay, status, data
    vecs[0] = '{1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0, 0, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 16'h0010, 32'h0, 4'hF, 3, 1'b0, 32'h12345678, 1'b0, 0, 2'b00, 32'h12345678};
    vecs[2] = '{1'b1, 16'h0020, 32'hCAFEF00D, 4'h3, 1, 1'b0, 32'h0, 1'b1, 0, 2'b10, 32'h0};
    vecs[3] = '{1'b0, 16'h0030, 32'h0, 4'h0, 0, 1'b0, 32'hAAAA5555, 1'b1, 0, 2'b10, 32'h0};
    vecs[4] = '{1'b0, 16'h0040, 32'h0, 4'h0, 0, 1'b1, 32'h0, 1'b0, 2, 2'b11, 32'h0};
    vecs[5] = '{1'b1, 16'h0050, 32'h01020304, 4'h5, 2, 1'b0, 32'h0, 1'b0, 0, 2'b00, 32'h0};
    vecs[6] = '{1'b0, 16'hFFFC, 32'h0, 4'h0, 0, 1'b0, 32'h89ABCDEF, 1'b0, 5, 2'b00, 32'h89ABCDEF};

    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.o_cmd_ready, bus.o_rsp_valid, bus.o_rsp_read_data, bus.o_rsp_status,
          bus.o_psel, bus.o_penable, bus.o_pwrite, bus.o_paddr, bus.o_pwdata, bus.o_pstrb}, 64'h0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", bus.o_cmd_ready, 0);
    @(negedge clk);
    check("ready_after_edge", bus.o_cmd_ready, 1);

    for (int i = 0; i < 7; i++) do_xfer(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      v.write     = 1'($urandom_range(0, 1));
      v.addr      = 16'($urandom);
      v.wdata     = $urandom;
      v.strb      = 4'($urandom_range(1, 15));
      v.waits     = $urandom_range(0, 3);
      v.hang      = 1'b0;
      v.prdata    = $urandom;
      v.slverr    = ($urandom_range(0, 3) == 0);
      v.rsp_delay = $urandom_range(0, 2);
      v.exp_status = v.slverr ? 2'b10 : 2'b00;
      v.exp_data   = (v.write || v.slverr) ? 32'h0 : v.prdata;
      do_xfer(v);
    end

    // Reset pulsed while the completer stalls in ACCESS.
    drive_cmd(1'b0, 16'h0060, 32'h0, 4'h0);
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_access", {bus.o_psel, bus.o_penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {bus.o_psel, bus.o_penable, bus.o_rsp_valid, bus.o_cmd_ready}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {bus.o_cmd_ready, bus.o_rsp_valid}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_rsp", {bus.o_rsp_valid, bus.o_psel}, 2'b00);
    end
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
